spectrum_frame_assembler: RTL and testbench
===========================================

# spectrum_frame_assembler

Consumes the byte stream from the ADC receive FIFO (the `dout`/`valid` pair on the `cclk` side) and rebuilds complete spectrum frames of `NUM_BINS` magnitude bytes. The frames are framed by a sync byte. Frames are assembled into a back buffer and swapped atomically into a front buffer, which the VGA controller reads bin-by-bin. This keeps the display tear-free and isolates it from partial or corrupted UART frames.

## Interface
Parameters:
- `NUM_BINS`, 64: bins per frame; power of two, 8..256.
- `SYNC_BYTE`, 8'hFF: frame-start marker; never a valid magnitude.
- `TIMEOUT_CYCLES`, 10000: max `cclk` cycles between bytes inside a frame (~4.8 byte times at 115200 baud, 24 MHz).

Ports:
- `cclk`, in, 1: single clock for the whole block.
- `reset`, in, 1: asynchronous, active-high reset.
- `rx_data`, in, 8: byte from the receive FIFO.
- `rx_valid`, in, 1: one-cycle strobe; `rx_data` is valid in the same cycle.
- `rd_bin`, in, log2(`NUM_BINS`): bin index requested by the VGA controller.
- `rd_mag`, out, 8: magnitude of `rd_bin` from the front buffer, registered.
- `frame_valid`, out, 1: high once at least one frame has been committed.
- `frame_ready`, out, 1: one-cycle pulse on each commit.
- `frame_count`, out, 8: committed frames; wraps 255→0.
- `err_count`, out, 8: aborted frames; saturates at 255.

## Operation
- The state machine has three states: HUNT, COLLECT and COMMIT.
- HUNT:
  - `rx_valid` with `rx_data`==`SYNC_BYTE` → COLLECT, with `idx`=0 and the timeout counter cleared.
  - All other bytes are discarded.
- COLLECT, on `rx_valid` with a non-sync byte:
  - Write `rx_data` to `back[idx]`, then `idx`++.
  - If the byte was written at `idx`==`NUM_BINS`-1 → COMMIT.
- COLLECT, on `rx_valid` with `SYNC_BYTE` (early resync):
  - `err_count`++ (saturating).
  - `idx`=0; stay in COLLECT. The new frame begins at once.
  - Bins already written to the back buffer are simply overwritten later.
- COLLECT timeout:
  - The timeout counter increments on every cycle without `rx_valid` and clears on `rx_valid`.
  - When it reaches `TIMEOUT_CYCLES` → HUNT, `err_count`++.
- COMMIT (always exactly one cycle):
  - Toggle `front_sel`.
  - Pulse `frame_ready`; `frame_count`++; set `frame_valid`=1 (sticky).
  - Go to HUNT.
  - An `rx_valid` arriving in the COMMIT cycle is evaluated with HUNT rules in that same cycle. A sync byte there goes directly to COLLECT, so no byte is lost.
- Back buffer is always `!front_sel`. The front buffer is never written.
- Memory contents are not reset. `frame_valid`=0 tells the VGA controller to blank the display until the first commit.
- Reset values: state HUNT; `idx`, timeout counter, `front_sel`, `frame_count`, `err_count` = 0; `frame_valid`, `frame_ready`, `rd_mag` = 0.
- Reset mid-frame discards the partial frame silently; `err_count` is not incremented.

## Timing
- Read latency is 1 cycle: `rd_mag` at edge t+1 = `front[rd_bin]` sampled at edge t.
- Swap coherency: the read at the edge where `front_sel` toggles uses the old `front_sel`. All later reads see the new frame. No read ever returns a mix of two frames for one address.
- Commit latency: the last bin's `rx_valid` is in cycle t. COMMIT is active in t+1, with `frame_ready`=1 and the counters updating at the end of t+1. New data is visible on `rd_mag` from cycle t+3.
- Back-to-back bytes (`rx_valid` on consecutive cycles) are accepted at full rate in every state.
- The timeout boundary is exact: after exactly `TIMEOUT_CYCLES` idle cycles the block is in HUNT. A byte arriving on cycle `TIMEOUT_CYCLES`-1 is still accepted.
- When `err_count` is at 255, a further error leaves it at 255. `frame_count` wraps.

## Structure
- A shared package/header `spectrum_pkg` holds:
  - `NUM_BINS`, `BIN_W`=log2(`NUM_BINS`), `SYNC_BYTE`;
  - the state encodings HUNT=2'd0, COLLECT=2'd1, COMMIT=2'd2.
  - The VGA controller reuses `NUM_BINS`/`BIN_W` from it.
- Sub-module `bin_ram_2p`: simple dual-port RAM, 2×`NUM_BINS`×8. Address = {`sel`,`bin`}. It has one synchronous write port and one registered read port, and infers block RAM.
- The FSM, counters and swap logic stay in the top module.

## Test plan
- Reset, then sync + 64 bytes 0..63 → one `frame_ready` pulse, `frame_count`=1, `frame_valid`=1. Reading `rd_bin`=10 gives `rd_mag`=10 one cycle later.
- Frame A (all 8'h11), then frame B sent while `rd_bin` sweeps continuously → reads return only 8'h11 until the swap edge and only B's values after it. Before frame A, `frame_valid`=0.
- Sync, 20 bytes, sync, 64 bytes of 8'h22 → `err_count`=1, `frame_count`=1, every bin = 8'h22.
- Sync, 30 bytes, then `TIMEOUT_CYCLES` idle cycles → HUNT, `err_count`=1, no `frame_ready`. Repeating with the gap at `TIMEOUT_CYCLES`-1 completes the frame normally.
- A sync byte in the COMMIT cycle with back-to-back `rx_valid`, followed by 64 bytes → two consecutive frames committed, `frame_count`=2.
- 256 good frames → `frame_count` wraps to 0. 300 timeouts → `err_count` holds at 255. Async `reset` mid-frame → all outputs return to reset values immediately.

Source files
------------

// File: rtl/spectrum_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the spectrum frame path (assembler and VGA controller).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package spectrum_pkg;

    localparam int         NUM_BINS  = 64;
    localparam int         BIN_W     = $clog2(NUM_BINS);
    localparam logic [7:0] SYNC_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_ram_2p.sv
`timescale 1ns/1ps
// Two-bank magnitude store: bank select in the address MSB, one write and one read port.
// Latency: write lands at the clock edge; rd_dat is registered, one cycle after rd_addr.
// Backpressure: none; both ports accept an access every cycle.
//
// Ports: cclk/reset (async, active high, clears only the read register),
//        wr_en/wr_addr/wr_dat write port, rd_addr/rd_dat registered read port.
module bin_ram_2p
    import spectrum_pkg::*;
#(
    parameter int BW = BIN_W
) (
    input  logic          cclk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [BW:0]   wr_addr,
    input  logic [7:0]    wr_dat,
    input  logic [BW:0]   rd_addr,
    output logic [7:0]    rd_dat
);

    logic [7:0] mem [0:(2**(BW+1))-1];

    // Array is left unreset so the tools can map it onto block RAM.
    always_ff @(posedge cclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            rd_dat <= 8'd0;
        end else begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spectrum_frame_assembler.sv
`timescale 1ns/1ps
// Rebuilds sync-delimited spectrum frames into a back buffer and swaps them atomically to the front.
// Latency: rd_mag one cycle after rd_bin; a frame is visible two cycles after its COMMIT cycle.
// Backpressure: none; a byte is accepted on every rx_valid cycle in every state.
//
// Ports: cclk, reset (async, active high); rx_data/rx_valid byte stream in;
//        rd_bin -> rd_mag registered front-buffer read; frame_valid (sticky),
//        frame_ready (commit pulse), frame_count (wrapping), err_count (saturating).
module spectrum_frame_assembler
    import spectrum_pkg::*;
#(
    parameter int         NUM_BINS       = spectrum_pkg::NUM_BINS,
    parameter logic [7:0] SYNC_BYTE      = spectrum_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 10000
) (
    input  logic                        cclk,
    input  logic                        reset,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic [$clog2(NUM_BINS)-1:0] rd_bin,
    output logic [7:0]                  rd_mag,
    output logic                        frame_valid,
    output logic                        frame_ready,
    output logic [7:0]                  frame_count,
    output logic [7:0]                  err_count
);

    localparam int BW = $clog2(NUM_BINS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state, state_nxt;
    logic [BW-1:0]   idx, idx_nxt;
    logic [TW-1:0]   tmo, tmo_nxt;
    logic            front_sel;
    logic            wr_en;
    logic            err_inc;
    logic            is_sync;

    assign is_sync     = (rx_data == SYNC_BYTE);
    assign frame_ready = (state == COMMIT);

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            idx         <= '0;
            tmo         <= '0;
            front_sel   <= 1'b0;
            frame_count <= 8'd0;
            err_count   <= 8'd0;
            frame_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tmo   <= tmo_nxt;
            if (state == COMMIT) begin
                front_sel   <= ~front_sel;
                frame_count <= frame_count + 8'd1;
                frame_valid <= 1'b1;
            end
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tmo_nxt   = tmo;
        wr_en     = 1'b0;
        err_inc   = 1'b0;
        case (state)
            // COMMIT lasts one cycle and applies HUNT rules to any byte in it,
            // so a sync arriving right behind the last bin is not lost.
            HUNT, COMMIT: begin
                state_nxt = HUNT;
                if (rx_valid && is_sync) begin
                    state_nxt = COLLECT;
                    idx_nxt   = '0;
                    tmo_nxt   = '0;
                end
            end
            COLLECT: begin
                if (rx_valid) begin
                    tmo_nxt = '0;
                    if (is_sync) begin
                        // Early resync: restart the frame in place, stale bins get overwritten.
                        err_inc = 1'b1;
                        idx_nxt = '0;
                    end else begin
                        wr_en   = 1'b1;
                        idx_nxt = idx + BW'(1);
                        if (idx == BW'(NUM_BINS - 1)) begin
                            state_nxt = COMMIT;
                        end
                    end
                end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    // This idle cycle is number TIMEOUT_CYCLES since the last byte.
                    state_nxt = HUNT;
                    err_inc   = 1'b1;
                    tmo_nxt   = '0;
                end else begin
                    tmo_nxt = tmo + TW'(1);
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    // Writes always go to the bank not being displayed; reads come from the displayed one.
    bin_ram_2p #(
        .BW (BW)
    ) u_ram (
        .cclk    (cclk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr ({~front_sel, idx}),
        .wr_dat  (rx_data),
        .rd_addr ({front_sel, rd_bin}),
        .rd_dat  (rd_mag)
    );

endmodule

// File: tb/tb_spectrum_frame_assembler.sv
`timescale 1ns/1ps
// Self-checking bench for spectrum_frame_assembler.
// Latency: reads compared one cycle after rd_bin is driven.
// Backpressure: n/a (DUT never stalls the byte stream).
module tb_spectrum_frame_assembler;

    localparam int NB  = 64;
    localparam int TMO = 20;

    logic       cclk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [5:0] rd_bin;
    logic [7:0] rd_mag;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] frame_count;
    logic [7:0] err_count;

    int n_chk = 0;
    int n_err = 0;
    int ready_cnt = 0;
    int rdy_exp = 0;
    int fc_exp = 0;
    int err_exp = 0;
    logic [7:0] pat [0:NB-1];
    logic [7:0] exp_q [$];

    spectrum_frame_assembler #(
        .NUM_BINS       (NB),
        .SYNC_BYTE      (8'hFF),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .cclk        (cclk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_bin      (rd_bin),
        .rd_mag      (rd_mag),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 cclk = ~cclk;

    always @(negedge cclk) begin
        if (frame_ready) ready_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic fill(input int base, input int step);
        for (int i = 0; i < NB; i++) pat[i] = 8'((base + i * step) & 8'hFF);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(pat[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Called in the COMMIT cycle (right after the last bin byte).
    task automatic expect_commit(input string tag);
        chk({tag, "_ready"}, int'(frame_ready), 1);
        rdy_exp++;
        fc_exp = (fc_exp + 1) & 8'hFF;
        tick();
        chk({tag, "_fcount"}, int'(frame_count), fc_exp);
        chk({tag, "_fvalid"}, int'(frame_valid), 1);
    endtask

    task automatic read_bin(input int b, input logic [7:0] exp);
        rd_bin = 6'(b);
        exp_q.push_back(exp);
        tick();
        chk("rd_mag", int'(rd_mag), int'(exp_q.pop_front()));
    endtask

    task automatic check_bins();
        for (int i = 0; i < NB; i++) read_bin(i, pat[i]);
    endtask

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_bin = 6'd0;
        tick(); tick();
        chk("rst_rd_mag", int'(rd_mag), 0);
        chk("rst_fvalid", int'(frame_valid), 0);
        chk("rst_fready", int'(frame_ready), 0);
        chk("rst_fcount", int'(frame_count), 0);
        chk("rst_errcnt", int'(err_count), 0);
        reset = 1'b0;
        tick();

        // Basic frame 0..63
        fill(0, 1);
        send_byte(8'hFF); send_range(0, NB - 1);
        expect_commit("f1");
        chk("f1_rdycnt", ready_cnt, rdy_exp);
        read_bin(10, 8'd10);
        read_bin(0, 8'd0);
        read_bin(63, 8'd63);

        // Frame A all 0x11, then frame B while rd_bin sweeps every cycle
        fill(8'h11, 0);
        send_byte(8'hFF); send_range(0, NB - 1);
        expect_commit("fa");
        fill(1, 3);
        for (int c = 0; c <= 80; c++) begin
            if (c == 0) begin
                rx_data = 8'hFF; rx_valid = 1'b1;
            end else if (c <= NB) begin
                rx_data = pat[c - 1]; rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            rd_bin = 6'(c % NB);
            // Cycle NB+1 is COMMIT: its read still uses the old bank.
            exp_q.push_back((c <= NB + 1) ? 8'h11 : pat[c % NB]);
            tick();
            chk("sweep_rd", int'(rd_mag), int'(exp_q.pop_front()));
        end
        rx_valid = 1'b0;
        rdy_exp++; fc_exp++;
        chk("fb_fcount", int'(frame_count), fc_exp);
        chk("fb_rdycnt", ready_cnt, rdy_exp);

        // Early resync
        fill(8'h50, 0);
        send_byte(8'hFF); send_range(0, 19);
        fill(8'h22, 0);
        send_byte(8'hFF); send_range(0, NB - 1);
        err_exp++;
        expect_commit("rs");
        chk("rs_errcnt", int'(err_count), err_exp);
        check_bins();

        // Timeout after exactly TMO idle cycles
        fill(8'h30, 1);
        send_byte(8'hFF); send_range(0, 29);
        idle(TMO);
        err_exp++;
        chk("to_errcnt", int'(err_count), err_exp);
        send_range(0, NB - 1);   // no sync: must be ignored in HUNT
        tick();
        chk("to_rdycnt", ready_cnt, rdy_exp);
        chk("to_fcount", int'(frame_count), fc_exp);

        // Gap of TMO-1 idle cycles is tolerated
        send_byte(8'hFF); send_range(0, 29);
        idle(TMO - 1);
        send_range(30, NB - 1);
        expect_commit("gap");
        chk("gap_errcnt", int'(err_count), err_exp);
        check_bins();

        // Sync byte in the COMMIT cycle
        fill(8'h40, 1);
        send_byte(8'hFF); send_range(0, NB - 1);
        chk("bb_ready1", int'(frame_ready), 1);
        rdy_exp++; fc_exp++;
        fill(8'h80, 1);
        send_byte(8'hFF); send_range(0, NB - 1);
        expect_commit("bb");
        chk("bb_rdycnt", ready_cnt, rdy_exp);
        check_bins();

        // Wrap frame_count after 256 frames from reset
        reset = 1'b1; tick(); reset = 1'b0; tick();
        fc_exp = 0; err_exp = 0;
        fill(0, 1);
        for (int f = 0; f < 256; f++) begin
            send_byte(8'hFF); send_range(0, NB - 1);
            rdy_exp++; fc_exp = (fc_exp + 1) & 8'hFF;
            tick();
        end
        chk("wrap_fcount", int'(frame_count), fc_exp);
        chk("wrap_fvalid", int'(frame_valid), 1);
        chk("wrap_rdycnt", ready_cnt, rdy_exp);

        // 300 timeouts: err_count saturates
        for (int k = 0; k < 300; k++) begin
            send_byte(8'hFF); send_byte(8'h07);
            idle(TMO);
            err_exp = (err_exp == 255) ? 255 : err_exp + 1;
            if (k == 254 || k == 299) chk("sat_errcnt", int'(err_count), err_exp);
        end

        // Async reset mid-frame
        send_byte(8'hFF); send_range(0, NB - 1);
        expect_commit("pre");
        read_bin(5, 8'd5);
        send_byte(8'hFF); send_range(0, 9);
        #3 reset = 1'b1;
        #1;
        chk("ar_rd_mag", int'(rd_mag), 0);
        chk("ar_fvalid", int'(frame_valid), 0);
        chk("ar_fready", int'(frame_ready), 0);
        chk("ar_fcount", int'(frame_count), 0);
        chk("ar_errcnt", int'(err_count), 0);
        tick();
        reset = 1'b0;
        fc_exp = 0;
        fill(8'h60, 1);
        send_byte(8'hFF); send_range(0, NB - 1);
        expect_commit("post");
        chk("post_errcnt", int'(err_count), 0);
        read_bin(7, pat[7]);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
